fifo_drain_ctrl: RTL and testbench
==================================

Name: fifo_drain_ctrl

Overview:
Read-side controller sitting directly downstream of fifo_mem. It watches the FIFO threshold and empty flags and issues trans_read pops. Popped words go into a one-entry output register and are presented on a valid/ready stream in bursts of BURST_LEN words, with a flush mode that drains the FIFO completely. It guarantees the FIFO never sees a read while empty, so the FIFO's underflow flag must never fire.

Parameters:
DATA_WIDTH, 16, width of FIFO words and m_data
BURST_LEN, 8, words per threshold-triggered burst; must be >= 1 and <= the FIFO THRESHOLD_VALUE
CNT_WIDTH, 16, width of word_count

Ports:
clk_in  input  1  single clock, rising edge
areset  input  1  asynchronous, active-high reset
enable  input  1  permits threshold-triggered bursts
flush_req  input  1  single-cycle request to drain the FIFO completely
fifo_data_out  input  DATA_WIDTH  fifo_mem data_out (first-word-fall-through: valid whenever empty is low)
fifo_empty_ind  input  1  fifo_mem empty_ind
fifo_threshold_ind  input  1  fifo_mem threshold_ind
fifo_trans_read  output  1  pop strobe to fifo_mem trans_read (combinational)
m_data  output  DATA_WIDTH  output word
m_valid  output  1  m_data valid
m_ready  input  1  downstream accepts the word
m_last  output  1  final word of a burst
busy  output  1  state != IDLE or m_valid
flush_done  output  1  one-cycle pulse when a flush completes
word_count  output  CNT_WIDTH  total accepted words, wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset (async, areset=1): state=IDLE; m_valid=0, m_data=0, m_last=0, flush_done=0, word_count=0; remaining=0; flush_pend=0; fifo_trans_read=0.
- States: IDLE, BURST, FLUSH.
- IDLE -> FLUSH when flush_req or flush_pend is set; flush has priority and clears flush_pend.
- IDLE -> BURST when enable=1 and fifo_threshold_ind=1; loads remaining=BURST_LEN.
- BURST -> IDLE on the cycle of a handshake (m_valid & m_ready) with m_last=1.
- FLUSH -> IDLE when fifo_empty_ind=1 and the output register is empty or handshaking this cycle. flush_done pulses high for that one cycle.
- flush_req in BURST or FLUSH: in BURST, set flush_pend and service it after the burst ends; in FLUSH, ignore it.
- enable deasserted mid-burst: the burst completes. enable only gates entry into BURST.
- Pop condition, combinational: fifo_trans_read = (state==BURST & remaining!=0 | state==FLUSH) & ~fifo_empty_ind & (~m_valid | m_ready).
- On a popping edge:
  - m_data <= fifo_data_out, m_valid <= 1.
  - In BURST, remaining decrements and m_last <= (remaining==1).
  - In FLUSH, m_last <= 0.
- On a handshake edge with no pop: m_valid <= 0, m_last <= 0.
- Throughput: 1 word/cycle while m_ready=1 and the FIFO is non-empty. Latency: pop edge to m_valid is 1 cycle.
- Empty mid-burst: popping stalls, with no reads while empty. The burst resumes when data arrives; m_last is still on word BURST_LEN.
- Backpressure: m_data, m_valid and m_last hold stable while m_valid=1 and m_ready=0.
- word_count increments on each handshake and wraps from all-ones to 0.
- Reset mid-burst: everything returns to reset values immediately; the in-flight word is discarded.
- Assertions:
  - never fifo_trans_read & fifo_empty_ind;
  - m_data stable under stall;
  - exactly BURST_LEN handshakes per burst.

Test Plan:
- Burst, no backpressure (BURST_LEN=4, behavioural FWFT FIFO model, THRESHOLD_VALUE=4, enable=1): write 0x0001..0x0004 -> 4 consecutive m_valid beats 0x0001..0x0004, m_last only on 0x0004, back to IDLE, word_count=4, FIFO underflow_ind never set.
- Backpressure: same burst, m_ready toggled 1,0,0,1,... -> every word is held stable while stalled, no word is dropped or duplicated, and the order is 0x0001..0x0004.
- Flush: 3 words 0x00A0..0x00A2 below threshold, flush_req pulse -> 3 beats with m_last=0, flush_done pulses 1 cycle after the final handshake, busy falls, word_count=3.
- Empty stall mid-burst: threshold forced high with only 2 words present, 2 more written 5 cycles later -> fifo_trans_read stays 0 while empty, burst resumes, m_last is on the 4th word.
- flush_req during a burst plus enable drop: after 6 words, flush_req mid-burst and enable=0 -> the burst finishes 4 words with m_last, then FLUSH drains the remaining 2 and flush_done pulses.
- Async reset mid-burst: areset high after 2 beats -> m_valid, m_last, word_count and fifo_trans_read go to 0 without waiting for a clock edge, and state=IDLE. After release, a new burst behaves as in the first scenario.

Source files
------------

// File: rtl/fifo_drain_ctrl_if.sv
// Output stream of the FIFO drain controller: one word per valid/ready beat,
// with a last marker on the final word of a burst.
interface fifo_drain_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/fifo_drain_ctrl.sv
// Read-side controller for fifo_mem: pops words into a one-entry output
// register and streams them out in fixed-length bursts or as a full flush.
// Never pops while the FIFO reports empty.
module fifo_drain_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_in,
  input  logic                  areset,
  input  logic                  enable,
  input  logic                  flush_req,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty_ind,
  input  logic                  fifo_threshold_ind,
  output logic                  fifo_trans_read,
  fifo_drain_ctrl_if.master     m_if,
  output logic                  busy,
  output logic                  flush_done,
  output logic [CNT_WIDTH-1:0]  word_count
);

  localparam int unsigned REM_W = $clog2(BURST_LEN + 1);
  localparam logic [REM_W-1:0] BURST_LOAD = REM_W'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, BURST, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [REM_W-1:0] remaining_q;
  logic             flush_pend_q, flush_pend_d;
  logic             handshake;
  logic             flush_exit;

  // Next-state, pending-flush bookkeeping and the combinational pop strobe
  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    flush_exit   = 1'b0;
    handshake    = m_if.m_valid & m_if.m_ready;
    fifo_trans_read = ((state_q == BURST && remaining_q != '0) || state_q == FLUSH)
                      && !fifo_empty_ind && (!m_if.m_valid || m_if.m_ready);
    case (state_q)
      IDLE: begin
        if (flush_req || flush_pend_q) begin
          state_d      = FLUSH;
          flush_pend_d = 1'b0;
        end else if (enable && fifo_threshold_ind) begin
          state_d = BURST;
        end
      end
      BURST: begin
        if (flush_req) flush_pend_d = 1'b1;
        if (handshake && m_if.m_last) state_d = IDLE;
      end
      FLUSH: begin
        if (fifo_empty_ind && (!m_if.m_valid || handshake)) begin
          state_d    = IDLE;
          flush_exit = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and pending-flush registers
  always_ff @(posedge clk_in or posedge areset) begin
    if (areset) begin
      state_q      <= IDLE;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Output register, burst word countdown, accepted-word counter, flush pulse
  always_ff @(posedge clk_in or posedge areset) begin
    if (areset) begin
      m_if.m_data  <= '0;
      m_if.m_valid <= 1'b0;
      m_if.m_last  <= 1'b0;
      remaining_q  <= '0;
      flush_done   <= 1'b0;
      word_count   <= '0;
    end else begin
      flush_done <= flush_exit;
      if (handshake) word_count <= word_count + CNT_WIDTH'(1);
      if (state_q == IDLE && state_d == BURST) begin
        remaining_q <= BURST_LOAD;
      end else if (fifo_trans_read && state_q == BURST) begin
        remaining_q <= remaining_q - REM_W'(1);
      end
      if (fifo_trans_read) begin
        m_if.m_data  <= fifo_data_out;
        m_if.m_valid <= 1'b1;
        m_if.m_last  <= (state_q == BURST) && (remaining_q == REM_W'(1));
      end else if (handshake) begin
        m_if.m_valid <= 1'b0;
        m_if.m_last  <= 1'b0;
      end
    end
  end

  assign busy = (state_q != IDLE) || m_if.m_valid;

  // The FIFO must never be popped while empty
  a_no_empty_read: assert property (@(posedge clk_in) disable iff (areset)
    !(fifo_trans_read && fifo_empty_ind));

  // A stalled word holds its data and last marker until accepted
  a_stall_stable: assert property (@(posedge clk_in) disable iff (areset)
    (m_if.m_valid && !m_if.m_ready) |=>
      (m_if.m_valid && $stable(m_if.m_data) && $stable(m_if.m_last)));

  // The last beat of a burst only leaves once all BURST_LEN words were popped
  a_burst_len: assert property (@(posedge clk_in) disable iff (areset)
    (handshake && m_if.m_last) |-> (state_q == BURST && remaining_q == '0));

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: behavioural FWFT FIFO in front, scoreboard
// queue of expected beats checked by an independent output monitor.
module tb_fifo_drain_ctrl;

  localparam int unsigned DW  = 16;
  localparam int unsigned BL  = 4;
  localparam int unsigned CW  = 16;
  localparam int          THR = 4;

  logic          clk = 1'b0;
  logic          areset = 1'b1;
  logic          enable = 1'b0;
  logic          flush_req = 1'b0;
  logic [DW-1:0] fifo_data_out;
  logic          fifo_empty_ind;
  logic          fifo_threshold_ind;
  logic          fifo_trans_read;
  logic          busy;
  logic          flush_done;
  logic [CW-1:0] word_count;

  fifo_drain_ctrl_if #(.DATA_WIDTH(DW)) m_if ();

  fifo_drain_ctrl #(.DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(CW)) dut (
    .clk_in             (clk),
    .areset             (areset),
    .enable             (enable),
    .flush_req          (flush_req),
    .fifo_data_out      (fifo_data_out),
    .fifo_empty_ind     (fifo_empty_ind),
    .fifo_threshold_ind (fifo_threshold_ind),
    .fifo_trans_read    (fifo_trans_read),
    .m_if               (m_if),
    .busy               (busy),
    .flush_done         (flush_done),
    .word_count         (word_count)
  );

  always #5 clk = ~clk;

  // Behavioural first-word-fall-through FIFO with sticky underflow flag
  logic [DW-1:0] mem [16];
  logic [3:0]    rd_ptr, wr_ptr;
  int            cnt;
  logic          underflow = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          force_thr = 1'b0;

  assign fifo_data_out      = mem[rd_ptr];
  assign fifo_empty_ind     = (cnt == 0);
  assign fifo_threshold_ind = (cnt >= THR) || force_thr;

  always @(posedge clk or posedge areset) begin
    if (areset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= 0;
    end else begin
      if (fifo_trans_read && cnt == 0) underflow <= 1'b1;
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 4'd1;
      end
      if (fifo_trans_read && cnt != 0) rd_ptr <= rd_ptr + 4'd1;
      cnt <= cnt + (wr_en ? 1 : 0) - ((fifo_trans_read && cnt != 0) ? 1 : 0);
    end
  end

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   flush_pulses = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input logic [DW-1:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  // Write n consecutive words starting at base, one per cycle
  task automatic write_words(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + DW'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (busy || exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: busy=%0b pending=%0d", name, busy, exp_q.size());
    end
  endtask

  // Downstream ready: always 1, or the 1,0,0,1 pattern in backpressure mode
  logic       bp_mode = 1'b0;
  logic [3:0] rdy_pat = 4'b1001;
  logic [1:0] pat_i = 2'd0;

  initial begin
    m_if.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        m_if.m_ready = rdy_pat[pat_i];
        pat_i = pat_i + 2'd1;
      end else begin
        m_if.m_ready = 1'b1;
      end
    end
  end

  // Output monitor: scoreboard pops on every handshake, plus stall and flush checks
  initial begin
    logic          prev_stall, prev_hs, prev_fd, prev_last;
    logic [DW-1:0] prev_data;
    exp_t          e;
    prev_stall = 1'b0;
    prev_hs    = 1'b0;
    prev_fd    = 1'b0;
    prev_last  = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (areset) begin
        prev_stall = 1'b0;
        prev_hs    = 1'b0;
        prev_fd    = 1'b0;
      end else begin
        if (prev_stall)
          check("stall_hold", 64'({m_if.m_valid, m_if.m_data, m_if.m_last}),
                64'({1'b1, prev_data, prev_last}));
        if (fifo_trans_read)
          check("no_read_when_empty", 64'(fifo_empty_ind), 64'(0));
        if (flush_done) begin
          flush_pulses++;
          check("flush_done_after_last_hs", 64'({prev_fd, prev_hs}), 64'(2'b01));
        end
        if (m_if.m_valid && m_if.m_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_beat: got data 0x%0h last %0b, expected none",
                     m_if.m_data, m_if.m_last);
          end else begin
            e = exp_q.pop_front();
            check("beat", 64'({m_if.m_data, m_if.m_last}), 64'({e.data, e.last}));
          end
        end
        prev_stall = m_if.m_valid && !m_if.m_ready;
        prev_hs    = m_if.m_valid && m_if.m_ready;
        prev_fd    = flush_done;
        prev_data  = m_if.m_data;
        prev_last  = m_if.m_last;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Directed scenarios
  initial begin
    int n;
    tick();
    tick();
    areset = 1'b0;
    tick();
    check("rst_m_valid", 64'(m_if.m_valid), 64'(0));
    check("rst_m_data", 64'(m_if.m_data), 64'(0));
    check("rst_m_last", 64'(m_if.m_last), 64'(0));
    check("rst_flush_done", 64'(flush_done), 64'(0));
    check("rst_word_count", 64'(word_count), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_trans_read", 64'(fifo_trans_read), 64'(0));

    // Threshold burst, no backpressure
    enable = 1'b1;
    for (int i = 1; i <= 4; i++) expect_beat(DW'(i), i == 4);
    write_words(16'h0001, 4);
    wait_idle("burst1", 50);
    check("burst1_word_count", 64'(word_count), 64'(4));
    check("burst1_underflow", 64'(underflow), 64'(0));

    // Same burst under 1,0,0,1 backpressure
    bp_mode = 1'b1;
    for (int i = 1; i <= 4; i++) expect_beat(DW'(i), i == 4);
    write_words(16'h0001, 4);
    wait_idle("backpressure", 80);
    bp_mode = 1'b0;
    tick();
    check("bp_word_count", 64'(word_count), 64'(8));

    // Flush of three words below threshold
    for (int i = 0; i < 3; i++) expect_beat(16'h00A0 + DW'(i), 1'b0);
    write_words(16'h00A0, 3);
    tick();
    check("flush_idle_before_req", 64'(busy), 64'(0));
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    wait_idle("flush", 50);
    tick();
    tick();
    check("flush_pulses", 64'(flush_pulses), 64'(1));
    check("flush_busy_low", 64'(busy), 64'(0));
    check("flush_word_count", 64'(word_count), 64'(11));

    // Empty stall mid-burst: threshold forced with two words present
    for (int i = 0; i < 4; i++) expect_beat(16'h0011 + DW'(i), i == 3);
    write_words(16'h0011, 2);
    force_thr = 1'b1;
    n = 0;
    while (!(exp_q.size() == 2 && !m_if.m_valid) && n < 30) begin
      tick();
      n++;
    end
    check("stall_reached", 64'(exp_q.size()), 64'(2));
    for (int i = 0; i < 5; i++) begin
      check("stall_no_read", 64'(fifo_trans_read), 64'(0));
      check("stall_busy", 64'(busy), 64'(1));
      tick();
    end
    write_words(16'h0013, 2);
    force_thr = 1'b0;
    wait_idle("empty_stall", 50);
    check("stall_word_count", 64'(word_count), 64'(15));

    // flush_req and enable drop mid-burst: burst of 4 then flush of 2
    for (int i = 0; i < 6; i++) expect_beat(16'h0021 + DW'(i), i == 3);
    write_words(16'h0021, 6);
    check("mid_burst_busy", 64'(busy), 64'(1));
    flush_req = 1'b1;
    enable    = 1'b0;
    tick();
    flush_req = 1'b0;
    wait_idle("burst_then_flush", 60);
    tick();
    tick();
    check("bf_flush_pulses", 64'(flush_pulses), 64'(2));
    check("bf_word_count", 64'(word_count), 64'(21));

    // Asynchronous reset in the middle of a burst
    enable = 1'b1;
    for (int i = 0; i < 4; i++) expect_beat(16'h0031 + DW'(i), i == 3);
    write_words(16'h0031, 4);
    n = 0;
    while (exp_q.size() > 2 && n < 30) begin
      tick();
      n++;
    end
    check("pre_reset_valid", 64'(m_if.m_valid), 64'(1));
    areset = 1'b1;
    #1;
    check("arst_m_valid", 64'(m_if.m_valid), 64'(0));
    check("arst_m_last", 64'(m_if.m_last), 64'(0));
    check("arst_word_count", 64'(word_count), 64'(0));
    check("arst_trans_read", 64'(fifo_trans_read), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    exp_q.delete();
    tick();
    tick();
    areset = 1'b0;
    tick();
    for (int i = 1; i <= 4; i++) expect_beat(DW'(i), i == 4);
    write_words(16'h0001, 4);
    wait_idle("post_reset_burst", 50);
    check("post_reset_word_count", 64'(word_count), 64'(4));
    check("final_underflow", 64'(underflow), 64'(0));
    check("final_flush_pulses", 64'(flush_pulses), 64'(2));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
